// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared operation encodings, FSM states and helpers for hilo_muldiv.
// Rev    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // Magnitude of a 32-bit operand; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_divider.sv
`default_nettype none
// ============================================================================
// Module : hilo_divider
// Brief  : 32-step restoring divider over operand magnitudes with sign fix-up
//          and MIPS-style divide-by-zero result. Used when MULDIV_DIV_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
module hilo_divider
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic [31:0] dividend;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic [32:0] shifted;
    logic [32:0] trial;

    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {1'b0, dvsr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            dividend <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            rem      <= '0;
            quo      <= md_mag(a, is_signed);
            dvsr     <= md_mag(b, is_signed);
            dividend <= a;
            neg_q    <= is_signed && (a[31] ^ b[31]);
            neg_r    <= is_signed && a[31];
            div_zero <= (b == 32'd0);
        end else if (step) begin
            // A clear borrow bit means the divisor fits into the partial remainder.
            if (!trial[32]) begin
                rem <= trial[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= shifted[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        quotient  = neg_q ? (~quo + 32'd1) : quo;
        remainder = neg_r ? (~rem + 32'd1) : rem;
        if (div_zero) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = dividend;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module : hilo_muldiv
// Brief  : Iterative HI/LO multiply/divide unit with fixed 33-cycle latency.
//          Divider included only when MULDIV_DIV_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module hilo_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] hilo
);

    localparam logic [MD_CNT_W-1:0] ITER_CNT = MD_CNT_W'(MD_ITER);

    md_state_t          state;
    md_state_t          state_nxt;
    logic [MD_CNT_W-1:0] cnt;
    logic               run_div;

    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic        mul_neg;
    logic [63:0] mul_res;

    logic        accept;
    logic        start_div;
    logic        iter_active;
    logic        last_cycle;
    logic        finish;
    logic [63:0] result;

    assign accept      = (state == ST_IDLE) && start && !cancel;
    assign start_div   = op[1];
    assign iter_active = (state == ST_RUN) && (cnt != ITER_CNT);
    assign last_cycle  = (state == ST_RUN) && (cnt == ITER_CNT);
    assign finish      = last_cycle && !cancel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef MULDIV_DIV_EN
                    state_nxt = ST_RUN;
`else
                    state_nxt = start_div ? ST_DONE : ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_nxt = ST_IDLE;
                end else if (last_cycle) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Iteration counter and inline shift-add multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            run_div <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mul_neg <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            run_div <= start_div;
            mcand   <= {32'd0, md_mag(a, op == MD_MULT)};
            mplier  <= md_mag(b, op == MD_MULT);
            acc     <= '0;
            mul_neg <= (op == MD_MULT) && (a[31] ^ b[31]);
        end else if (iter_active) begin
            cnt <= cnt + 1'b1;
            if (!run_div) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= {mcand[62:0], 1'b0};
                mplier <= {1'b0, mplier[31:1]};
            end
        end
    end

    assign mul_res = mul_neg ? (~acc + 64'd1) : acc;

`ifdef MULDIV_DIV_EN
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    hilo_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && start_div),
        .step      (iter_active && run_div),
        .a         (a),
        .b         (b),
        .is_signed (op == MD_DIV),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign result = run_div ? {div_rem, div_quo} : mul_res;
`else
    assign result = mul_res;
`endif

    // Completion is written last so it overrides a same-edge mthi/mtlo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (wr_hi) begin
                hi <= wdata;
            end
            if (wr_lo) begin
                lo <= wdata;
            end
            if (finish) begin
                hi <= result[63:32];
                lo <= result[31:0];
            end
        end
    end

    assign hilo = {hi, lo};
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module : tb_hilo_muldiv
// Brief  : Directed self-checking bench for hilo_muldiv (honours MULDIV_DIV_EN).
// Rev    : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [63:0] hilo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    hilo_muldiv dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hilo   (hilo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n, output logic seen);
        n = 0;
        while (!done && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        seen = done;
    endtask

    task automatic wait_no_done(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic step_idle(input string name);
        @(posedge clk);
        #1;
        check({name, " idle after done"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        seen;
        logic        skip;
        logic        lat_ok;
        logic [63:0] model;
        logic [63:0] exp;

        rst = 1'b1; start = 1'b0; op = MD_MULT; a = '0; b = '0;
        cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hilo", hilo, 64'd0);
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model = 64'd0;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3]  = '{MD_DIVU,  32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF};
        vecs[4]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[5]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[6]  = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[7]  = '{MD_DIVU,  32'd100,       32'd7,        64'h0000_0002_0000_000E};
        vecs[8]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFDD};
        vecs[9]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[10] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,        64'hFFFF_FFFB_FFFF_FFFF};
        vecs[11] = '{MD_MULT,  32'd0,         32'hFFFF_FFFF, 64'h0000_0000_0000_0000};
        vecs[12] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,        64'h0000_0000_FFFF_FFFF};
        vecs[13] = '{MD_MULTU, 32'h1234_5678, 32'h10,       64'h0000_0001_2345_6780};
        vecs[14] = '{MD_MULT,  32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000};

        for (int i = 0; i < 15; i++) begin
            skip = vecs[i].op[1] && !DIV_EN;
            exp  = skip ? model : vecs[i].exp;
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d busy after start", i), {63'd0, busy}, 64'd1);
            wait_done(40, lat, seen);
            check($sformatf("vec%0d done seen", i), {63'd0, seen}, 64'd1);
            lat_ok = skip ? (lat <= 1) : (lat == 33);
            check($sformatf("vec%0d latency=%0d ok", i, lat), {63'd0, lat_ok}, 64'd1);
            check($sformatf("vec%0d hilo", i), hilo, exp);
            model = exp;
            step_idle($sformatf("vec%0d", i));
        end

        // Cancel mid-run: no done, HI/LO keep prior value; rerun completes.
        issue(MD_MULTU, 32'd2, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel busy", {63'd0, busy}, 64'd0);
        wait_no_done(40, seen);
        check("cancel no done", {63'd0, seen}, 64'd0);
        check("cancel hilo kept", hilo, model);
        issue(MD_MULTU, 32'd2, 32'd3);
        wait_done(40, lat, seen);
        check("rerun latency", 64'(lat), 64'd33);
        check("rerun hilo", hilo, 64'd6);
        model = 64'd6;
        step_idle("rerun");

        // Direct writes in IDLE.
        wr_hi = 1'b1; wdata = 32'hDEAD;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        check("mthi idle", hilo, {32'hDEAD, 32'd6});
        wr_lo = 1'b1; wdata = 32'hAB;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        check("mtlo idle", hilo, {32'hDEAD, 32'hAB});
        model = {32'hDEAD, 32'hAB};

        // Direct write colliding with completion: completion wins.
        issue(MD_MULTU, 32'd2, 32'd3);
        repeat (32) @(posedge clk);
        #1;
        check("no partial result", hilo, model);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234;
        @(posedge clk);
        #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("collide done", {63'd0, done}, 64'd1);
        check("collide hilo", hilo, 64'd6);
        model = 64'd6;
        step_idle("collide");

        // Direct write during RUN lands next edge; result later overwrites it.
        issue(MD_MULTU, 32'd5, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        wr_hi = 1'b1; wdata = 32'h55;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        check("mthi in run", hilo, {32'h55, 32'd6});
        check("mthi in run busy", {63'd0, busy}, 64'd1);
        wait_done(40, lat, seen);
        check("run-write latency", 64'(lat + 6), 64'd33);
        check("run-write hilo", hilo, 64'd35);
        model = 64'd35;
        step_idle("run-write");

        // Start while busy is ignored, even with changed operands.
        issue(MD_MULT, 32'd9, 32'hFFFF_FFFC);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; op = MD_MULTU; a = 32'd100; b = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, lat, seen);
        check("busy-start latency", 64'(lat + 4), 64'd33);
        check("busy-start hilo", hilo, 64'hFFFF_FFFF_FFFF_FFDC);
        model = 64'hFFFF_FFFF_FFFF_FFDC;
        step_idle("busy-start");

        // Cancel and start together in IDLE: start dropped.
        start = 1'b1; cancel = 1'b1; op = MD_MULTU; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel+start busy", {63'd0, busy}, 64'd0);
        wait_no_done(40, seen);
        check("cancel+start no done", {63'd0, seen}, 64'd0);
        check("cancel+start hilo", hilo, model);

        // Cancel on the final RUN cycle suppresses the write.
        issue(MD_MULTU, 32'd2, 32'd3);
        repeat (32) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("late cancel busy/done", {62'd0, busy, done}, 64'd0);
        check("late cancel hilo", hilo, model);
        wait_no_done(5, seen);
        check("late cancel no done", {63'd0, seen}, 64'd0);

        // Asynchronous reset mid-run.
        issue(MD_MULT, 32'd7, 32'hFFFF_FFFB);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst hilo", hilo, 64'd0);
        check("async rst busy/done", {62'd0, busy, done}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_no_done(40, seen);
        check("post-rst no done", {63'd0, seen}, 64'd0);
        check("post-rst hilo", hilo, 64'd0);

        issue(MD_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
        wait_done(40, lat, seen);
        check("recover latency", 64'(lat), 64'd33);
        check("recover hilo", hilo, 64'h0000_0000_FFFE_0001);
        step_idle("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  request new operation.
REQ-004 SHALL have ports: op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-005 SHALL have ports: a, b  in  32 each  operands (rs, rt); sampled only on an accepted start.
REQ-006 SHALL have ports: cancel  in  1  pipeline flush; abort the in-flight operation.
REQ-007 SHALL have ports: wr_hi, wr_lo  in  1 each  direct HI/LO write (mthi/mtlo); wdata  in  32.
REQ-008 SHALL have ports: busy  out  1  (state != IDLE); done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports: hilo  out  64  {HI, LO} register contents, fed to the ALU hilo input.
REQ-010 SHALL clock all state on clk; rst SHALL act asynchronously and active-high.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on start.
- RUN->DONE after exactly 32 RUN cycles.
- DONE->IDLE unconditionally.
REQ-012 SHALL accept start only in IDLE; start in RUN or DONE SHALL be ignored.
REQ-013 SHALL give fixed latency: start sampled at edge N; HI/LO updated at edge N+33; done=1 during cycle N+33..N+34.
REQ-014 SHALL compute MULT/MULTU as radix-2 shift-add over operand magnitudes, one bit per RUN cycle.
- Signed result SHALL be negated when sign(a) xor sign(b).
- Result width: 64 bits; HI = product[63:32], LO = product[31:0].
REQ-015 SHALL compute DIV/DIVU by 32-step restoring division over magnitudes.
- LO = quotient; HI = remainder.
- Signed: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
REQ-016 SHALL, on division by zero, set HI=a and LO=32'hFFFFFFFF, for both DIV and DIVU, with unchanged latency.
REQ-017 SHALL handle signed DIV of 0x80000000 / 0xFFFFFFFF as LO=0x80000000, HI=0 (wrap, no trap).
REQ-018 SHALL, on cancel in RUN or DONE, return to IDLE next edge with HI/LO unchanged and no done; cancel in IDLE SHALL have no effect.
REQ-019 SHALL, on cancel and start in the same IDLE cycle, give cancel priority (start is dropped).
REQ-020 SHALL apply wr_hi/wr_lo in any state at the next edge.
REQ-021 SHALL, when a direct write and a completion land on the same edge, let the completion win for both halves.
REQ-022 SHALL drive hilo combinationally from the HI/LO registers only; partial results SHALL never be visible.

Reset
REQ-023 SHALL, on rst, force state=IDLE, HI=0, LO=0, busy=0, done=0, and clear all iteration counters and datapath registers.
REQ-024 SHALL, on rst asserted mid-operation, abandon the operation with no done pulse after release.

Configuration
REQ-025 SHALL include the divider only when MULDIV_DIV_EN is defined.
REQ-026 SHALL, without MULDIV_DIV_EN, treat DIV/DIVU as IDLE->DONE (1 RUN-free cycle): done pulses at edge N+1 and HI/LO stay unchanged. MULT/MULTU SHALL be unaffected.

Structure
REQ-027 SHALL place in shared package muldiv_pkg:
- op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
- FSM state enum;
- MD_ITER=32.
REQ-028 SHALL put the restoring-division datapath in sub-module hilo_divider, instantiated only under MULDIV_DIV_EN. The multiplier SHALL stay inline.

Verification
REQ-029 SHALL test MULT a=0xFFFFFFFE (-2), b=3 -> after 33 cycles hilo=0xFFFFFFFF_FFFFFFFA, done one cycle, busy low next.
REQ-030 SHALL test MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hilo=0xFFFFFFFE_00000001.
REQ-031 SHALL test DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIVU a=5, b=0 -> HI=5, LO=0xFFFFFFFF.
REQ-032 SHALL test MULTU 2x3 with cancel at RUN cycle 10 -> no done, hilo keeps prior value. A second start then completes normally with hilo=6.
REQ-033 SHALL test wr_hi=1, wdata=0x1234 in the completion cycle of MULTU 2x3 -> hilo=0x00000000_00000006. wr_lo=0xAB in IDLE -> LO=0xAB next edge.
REQ-034 SHALL test rst pulsed mid-RUN -> hilo=0, busy=0 immediately (async), no done; start ignored during busy (changed operands do not alter the result).
